ddr3_request_arbiter: RTL

DDR3_REQUEST_ARBITER -- requirements
Module: ddr3_request_arbiter

---
 rtl/ddr3_request_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ddr3_request_arbiter.sv
// Two-requester front end for a DDR3 controller. It grants round-robin, holds one
// command at a time, and returns read data to whichever requester issued the read.
// Latency: req_ready is raised in the granting IDLE cycle. The enable goes high on the
//          next cycle. rsp_valid follows read acceptance by READ_LATENCY+1 cycles.
// Backpressure: a requester holds req_valid until req_ready. Once granted, the command
//               is held in ISSUE until main_state shows acceptance or TIMEOUT expires.
//
// Ports:
//   clk, reset          single clock; asynchronous active-high reset
//   req_valid/ready     per-requester handshake (bit n = requester n)
//   req_write           per-requester direction (1 = write)
//   req_address/data    per-requester address and write data, packed by requester index
//   rsp_valid/data      one-cycle read response (owner bit) and shared read data
//   timeout_error       sticky flag: a command was abandoned
//   write_enable, read_enable, i_user_data_address, data_to_ram  command to the controller
//   data_from_ram, main_state                                   status from the controller
module ddr3_request_arbiter #(
    parameter int unsigned ADDRESS_BITWIDTH      = 15,
    parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
    parameter int unsigned DQ_BITWIDTH           = 16,
    parameter logic [4:0]  STATE_WRITE_DATA      = 5'd8,
    parameter logic [4:0]  STATE_READ_DATA       = 5'd11,
    parameter int unsigned READ_LATENCY          = 6,
    parameter int unsigned TIMEOUT               = 1023
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic [1:0]                                              req_valid,
    output logic [1:0]                                              req_ready,
    input  logic [1:0]                                              req_write,
    input  logic [2*(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH)-1:0]   req_address,
    input  logic [2*DQ_BITWIDTH-1:0]                                req_data,
    output logic [1:0]                                              rsp_valid,
    output logic [DQ_BITWIDTH-1:0]                                  rsp_data,
    output logic                                                    timeout_error,
    output logic                                                    write_enable,
    output logic                                                    read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0]       i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                                  data_to_ram,
    input  logic [DQ_BITWIDTH-1:0]                                  data_from_ram,
    input  logic [4:0]                                              main_state
);

    localparam int unsigned AW     = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [3:0]        LAT_LOAD  = 4'(READ_LATENCY - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    owner_q;        // requester that owns the outstanding command
    logic                    last_q;         // requester granted most recently
    logic                    is_write_q;
    logic                    we_q;
    logic                    re_q;
    logic [AW-1:0]           addr_q;
    logic [DQ_BITWIDTH-1:0]  wdata_q;
    logic [DQ_BITWIDTH-1:0]  rsp_data_q;
    logic [1:0]              rsp_valid_q;
    logic                    timeout_q;
    logic [3:0]              lat_cnt_q;
    logic [WAIT_W-1:0]       wait_cnt_q;

    // Grant decision for the current IDLE cycle.
    logic                    grant_vld_d;
    logic                    grant_idx_d;
    logic                    grant_write_d;
    logic [AW-1:0]           grant_addr_d;
    logic [DQ_BITWIDTH-1:0]  grant_data_d;
    logic                    accept_d;
    logic                    timeout_hit_d;
    logic [1:0]              owner_onehot_d;

    always_comb begin
        grant_vld_d = (state_q == IDLE) && (req_valid != 2'b00);
        case (req_valid)
            2'b01:   grant_idx_d = 1'b0;
            2'b10:   grant_idx_d = 1'b1;
            // On a tie, the requester that was not granted last wins.
            2'b11:   grant_idx_d = ~last_q;
            default: grant_idx_d = 1'b0;
        endcase
        grant_write_d = grant_idx_d ? req_write[1] : req_write[0];
        grant_addr_d  = grant_idx_d ? req_address[2*AW-1:AW] : req_address[AW-1:0];
        grant_data_d  = grant_idx_d ? req_data[2*DQ_BITWIDTH-1:DQ_BITWIDTH]
                                    : req_data[DQ_BITWIDTH-1:0];
    end

    always_comb begin
        accept_d       = is_write_q ? (main_state == STATE_WRITE_DATA)
                                    : (main_state == STATE_READ_DATA);
        // wait_cnt_q counts completed ISSUE cycles, so TIMEOUT-1 marks the last one.
        timeout_hit_d  = (wait_cnt_q == WAIT_LAST);
        owner_onehot_d = {owner_q, ~owner_q};
    end

    // The handshake is combinational so that ready lands in the granting IDLE cycle
    // itself. It is gated by reset so no grant is seen while reset is held.
    assign req_ready = (grant_vld_d && !reset) ? {grant_idx_d, ~grant_idx_d} : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;      // requester 0 wins the first tie
            is_write_q  <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 2'b00;
            timeout_q   <= 1'b0;
            lat_cnt_q   <= '0;
            wait_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        owner_q    <= grant_idx_d;
                        last_q     <= grant_idx_d;
                        is_write_q <= grant_write_d;
                        addr_q     <= grant_addr_d;
                        wdata_q    <= grant_data_d;
                        we_q       <= grant_write_d;
                        re_q       <= ~grant_write_d;
                        wait_cnt_q <= '0;
                        state_q    <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Acceptance takes priority over a timeout in the same cycle.
                    if (accept_d) begin
                        we_q <= 1'b0;
                        re_q <= 1'b0;
                        if (is_write_q) begin
                            state_q <= IDLE;
                        end else begin
                            lat_cnt_q <= LAT_LOAD;
                            state_q   <= RD_WAIT;
                        end
                    end else if (timeout_hit_d) begin
                        we_q      <= 1'b0;
                        re_q      <= 1'b0;
                        timeout_q <= 1'b1;
                        if (is_write_q) begin
                            state_q <= IDLE;
                        end else begin
                            // An abandoned read still completes, with zero data, so the
                            // requester is never left waiting forever.
                            rsp_data_q  <= '0;
                            rsp_valid_q <= owner_onehot_d;
                            state_q     <= RESP;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_ONE;
                    end
                end

                RD_WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        rsp_data_q  <= data_from_ram;
                        rsp_valid_q <= owner_onehot_d;
                        state_q     <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign write_enable        = we_q;
    assign read_enable         = re_q;
    assign i_user_data_address = addr_q;
    assign data_to_ram         = wdata_q;
    assign rsp_data            = rsp_data_q;
    assign rsp_valid           = rsp_valid_q;
    assign timeout_error       = timeout_q;

endmodule
